clkdiv_monitor: RTL

- Receiving end of the team's ripple T-flip-flop divider chain.
- Samples one divided-clock output (e.g. the last tff stage) as an asynchronous input, synchronizes it and detects its rising edges.
- Measures the period in clk cycles and checks it against an expected division ratio.
- Reports lock, mismatch and stall status for bench and self-test use next to the divider.

---
 rtl/clkdiv_monitor_pkg.sv | 17 +
 rtl/clkdiv_monitor_sync_edge_det.sv | 52 +++++
 rtl/clkdiv_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clkdiv_monitor_pkg.sv
// Shared types and default parameters for the divided-clock period monitor.
package clkdiv_monitor_pkg;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_EXP_PERIOD = 16;
  localparam int unsigned DEF_TOL        = 0;
  localparam int unsigned DEF_LOCK_CNT   = 4;
  localparam int unsigned MATCH_W        = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    LOCKED     = 2'd3
  } state_t;

endpackage

// File: rtl/clkdiv_monitor_sync_edge_det.sv
// Synchronizes the asynchronous divided clock and emits a registered rising-edge pulse.
// CLKDIV_MONITOR_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronizer.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic tick_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;
  logic det;

`ifdef CLKDIV_MONITOR_GLITCH_FILTER_EN
  logic m1;
  logic m2;
  logic filt;

  // Majority of three consecutive synchronized samples; single-cycle pulses never win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1   <= 1'b0;
      m2   <= 1'b0;
      filt <= 1'b0;
    end else begin
      m1   <= s2;
      m2   <= m1;
      filt <= (s2 & m1) | (s2 & m2) | (m1 & m2);
    end
  end

  assign det = filt;
`else
  assign det = s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= tick_in;
      s2   <= s1;
      s3   <= det;
      rise <= det & ~s3;
    end
  end

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures the period of a divided clock in clk cycles and reports lock, mismatch and stall.
// Optional glitch filter in the edge detector: CLKDIV_MONITOR_GLITCH_FILTER_EN.
module clkdiv_monitor
  import clkdiv_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             stall
);

  localparam int unsigned          W1      = CNT_W + 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};
  localparam logic [W1-1:0]        EXP_W   = W1'(EXP_PERIOD);
  localparam logic [W1-1:0]        TOL_W   = W1'(TOL);
  localparam logic [MATCH_W-1:0]   LOCK_M  = MATCH_W'(LOCK_CNT);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_nxt;
  logic [MATCH_W-1:0] match_inc;
  logic [CNT_W-1:0]   period_nxt;
  logic               valid_nxt;
  logic               locked_nxt;
  logic               mismatch_set;
  logic               stall_set;
  logic               rise;
  logic               sat;
  logic               in_tol;
  logic               lock_hit;
  logic [W1-1:0]      cnt_w;

  sync_edge_det u_sync (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .rise    (rise)
  );

  // Tolerance window evaluated one bit wider without subtraction, so no wrap.
  assign cnt_w     = W1'(cnt);
  assign in_tol    = ((cnt_w + TOL_W) >= EXP_W) && (cnt_w <= (EXP_W + TOL_W));
  assign sat       = (cnt == CNT_MAX);
  assign cnt_inc   = sat ? cnt : cnt + CNT_W'(1);
  assign match_inc = (match == LOCK_M) ? match : match + MATCH_W'(1);
  assign lock_hit  = (match_inc == LOCK_M);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       state_nxt = WAIT_FIRST;
        WAIT_FIRST: if (rise) state_nxt = MEASURE;
        MEASURE, LOCKED: begin
          if (rise) begin
            if (!in_tol)       state_nxt = MEASURE;
            else if (lock_hit) state_nxt = LOCKED;
          end else if (sat) begin
            state_nxt = WAIT_FIRST;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values for counter and registered status; an edge wins over a coincident stall.
  always_comb begin
    cnt_nxt      = cnt;
    match_nxt    = match;
    period_nxt   = period;
    valid_nxt    = 1'b0;
    locked_nxt   = locked;
    mismatch_set = 1'b0;
    stall_set    = 1'b0;
    if (!enable) begin
      cnt_nxt    = '0;
      match_nxt  = '0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE:       cnt_nxt = '0;
        WAIT_FIRST: cnt_nxt = rise ? CNT_W'(1) : cnt_inc;
        MEASURE, LOCKED: begin
          if (rise) begin
            cnt_nxt    = CNT_W'(1);
            period_nxt = cnt;
            valid_nxt  = 1'b1;
            if (in_tol) begin
              match_nxt  = match_inc;
              locked_nxt = lock_hit;
            end else begin
              match_nxt    = '0;
              locked_nxt   = 1'b0;
              mismatch_set = 1'b1;
            end
          end else if (sat) begin
            stall_set  = 1'b1;
            match_nxt  = '0;
            locked_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      match        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      stall        <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      match        <= match_nxt;
      period       <= period_nxt;
      period_valid <= valid_nxt;
      locked       <= locked_nxt;
      mismatch     <= mismatch_set | (mismatch & ~clr);
      stall        <= stall_set | (stall & ~clr);
    end
  end

endmodule
